// File: rtl/bal_vec_logger.sv
// bal_vec_logger: captures {stim, resp} pairs on a sample strobe into a FIFO
// and serializes each 56-bit record MSB-first onto a byte valid/ready stream.
// Optional build macro: BAL_VEC_LOG_CHKSUM_EN appends an XOR checksum byte
// after the seven record bytes.
module bal_vec_logger #(
    parameter int DEPTH   = 16,
    parameter int NUM_VEC = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arm,
    input  logic                           smp,
    input  logic [31:0]                    stim_in,
    input  logic [23:0]                    resp_in,
    output logic [7:0]                     byte_out,
    output logic                           byte_vld,
    input  logic                           byte_rdy,
    output logic                           busy,
    output logic                           done,
    output logic                           ovfl,
    output logic [$clog2(NUM_VEC+1)-1:0]   vec_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int VW = $clog2(NUM_VEC + 1);
    localparam int RW = 56;
`ifdef BAL_VEC_LOG_CHKSUM_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif
    localparam int SW = NB * 8;
    localparam int BW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_ovfl;
    logic [VW-1:0]   r_vec_cnt;

    logic [RW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [SW-1:0]   r_shift;
    logic [BW-1:0]   r_left;
    logic            r_vld;
    logic [7:0]      r_out;

    logic            w_full;
    logic            w_empty;
    logic            w_active;
    logic            w_start;
    logic            w_hs;
    logic            w_last;
    logic            w_pop;
    logic            w_smp_ok;
    logic            w_push;
    logic            w_drained;
    logic [RW-1:0]   w_head;
    logic [SW-1:0]   w_load;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_active  = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
    assign w_start   = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hs      = r_vld && byte_rdy;
    assign w_last    = (r_left == '0);
    // Load a new record when the shifter is empty, or when its final byte is
    // leaving this cycle so consecutive records run back-to-back.
    assign w_pop     = w_active && !w_empty && (!r_vld || (w_hs && w_last));
    assign w_smp_ok  = (r_state == S_CAPTURE) && smp;
    // A full FIFO still takes a sample if a slot frees up in the same cycle.
    assign w_push    = w_smp_ok && (!w_full || w_pop);
    // After this edge nothing remains in the FIFO or the shifter.
    assign w_drained = w_empty && (!r_vld || (w_hs && w_last));

    assign w_head    = r_mem[r_rptr];

`ifdef BAL_VEC_LOG_CHKSUM_EN
    logic [7:0] w_chk;

    // XOR of the seven record bytes, appended as the final byte
    always_comb begin
        w_chk = '0;
        for (int i = 0; i < 7; i++) begin
            w_chk = w_chk ^ w_head[i*8 +: 8];
        end
    end
    assign w_load = {w_head, w_chk};
`else
    assign w_load = w_head;
`endif

    // Run control: state, run counters and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovfl    <= 1'b0;
            r_vec_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        r_state   <= S_CAPTURE;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_ovfl    <= 1'b0;
                        r_vec_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_push) begin
                        r_vec_cnt <= r_vec_cnt + 1'b1;
                        if (r_vec_cnt == VW'(NUM_VEC - 1)) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_smp_ok) begin
                        r_ovfl <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Record storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {stim_in, resp_in};
        end
    end

    // FIFO pointers and occupancy count, cleared at the start of each run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_start) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte serializer: holds the current byte until handshake, then shifts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_left  <= '0;
            r_vld   <= 1'b0;
            r_out   <= '0;
        end else if (w_start) begin
            r_shift <= '0;
            r_left  <= '0;
            r_vld   <= 1'b0;
        end else if (w_pop) begin
            r_out   <= w_load[SW-1 -: 8];
            r_shift <= w_load << 8;
            r_left  <= BW'(NB - 1);
            r_vld   <= 1'b1;
        end else if (w_hs) begin
            if (w_last) begin
                r_vld <= 1'b0;
            end else begin
                r_out   <= r_shift[SW-1 -: 8];
                r_shift <= r_shift << 8;
                r_left  <= r_left - 1'b1;
            end
        end
    end

    assign byte_out = r_out;
    assign byte_vld = r_vld;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ovfl     = r_ovfl;
    assign vec_cnt  = r_vec_cnt;

endmodule

// File: doc/bal_vec_logger.md
# bal_vec_logger

Captures the balance-controller interface (32-bit stimulus word, 24-bit response word) once per sample strobe and buffers each pair as a 56-bit record in a FIFO. Records are serialized MSB-first onto a byte-wide valid/ready stream. This is the writer side of the stimulus/response hex vectors consumed by the self-checking `balance_cntrl` bench. It sits beside `balance_cntrl` in the segway top and feeds the UART/debug byte sink.

## Interface
- `DEPTH`, 16: FIFO entries (power of 2, ≥2).
- `NUM_VEC`, 1000: records accepted per capture run.
- `clk` input 1: system clock. All logic is rising-edge.
- `rst` input 1: reset, asynchronous and active-high.
- `arm` input 1: single-cycle pulse that starts a capture run. Honoured only in IDLE or DONE.
- `smp` input 1: sample strobe. When high in CAPTURE, the current `stim_in`/`resp_in` are pushed.
- `stim_in` input 32: `{rst_n, vld, ptch[15:0], ld_cell_diff[11:0], rider_off, en_steer}`.
- `resp_in` input 24: `{lft_rev, lft_spd[10:0], rght_rev, rght_spd[10:0]}`.
- `byte_out` output 8: serialized record byte.
- `byte_vld` output 1: `byte_out` is valid.
- `byte_rdy` input 1: sink accepts the byte when `byte_vld & byte_rdy` at a rising edge.
- `busy` output 1: high in CAPTURE or DRAIN.
- `done` output 1: high in DONE.
- `ovfl` output 1: sticky; a sample was dropped because the FIFO was full.
- `vec_cnt` output `$clog2(NUM_VEC+1)`: number of records accepted this run.

## Operation
- States: IDLE → (arm) CAPTURE → (`vec_cnt==NUM_VEC`) DRAIN → (FIFO empty and serializer idle) DONE → (arm) CAPTURE.
- On entry to CAPTURE:
  - `vec_cnt`, `ovfl`, FIFO pointers and serializer are cleared.
  - The `arm` cycle itself does not sample.
- Push in CAPTURE when `smp` is high and either the FIFO is not full, or a serializer pop occurs in the same cycle.
  - An accepted push increments `vec_cnt`.
  - A rejected push sets `ovfl` and does not increment `vec_cnt`.
- The cycle `vec_cnt` reaches `NUM_VEC`, the state becomes DRAIN. `smp` is ignored from then on.
- Serializer: when its shift register is empty and the FIFO is non-empty, it pops one record.
  - Without the configuration macro it emits 7 bytes: `stim[31:24]`, `stim[23:16]`, `stim[15:8]`, `stim[7:0]`, `resp[23:16]`, `resp[15:8]`, `resp[7:0]`.
  - When the handshake completes on the last byte and the FIFO is non-empty, it pops the next record in the same cycle (back-to-back records, no bubble).
- The serializer runs in both CAPTURE and DRAIN. In IDLE and DONE it is idle.
- `arm` in CAPTURE or DRAIN is ignored.
- `rst` at any point aborts the run and returns the block to reset values.

## Timing
- Reset values: state IDLE, `byte_out=0`, `byte_vld=0`, `busy=0`, `done=0`, `ovfl=0`, `vec_cnt=0`, FIFO empty.
- All outputs are registered.
- Latency: push at edge N → pop/load at edge N+1 → `byte_vld=1` after edge N+1 with the first byte.
- Valid/ready rules:
  - `byte_vld` and `byte_out` stay stable until the handshake completes.
  - The next byte appears the cycle after the handshake.
  - A `byte_rdy` that is high while `byte_vld=0` has no effect.
- DRAIN→DONE transition: on the edge where the final byte's handshake completes, the FIFO is empty. `done=1` from the following cycle.
- FIFO full and FIFO empty are derived from a `DEPTH+1`-state occupancy count. Pointers wrap modulo `DEPTH`.

## Configuration
- `BAL_VEC_LOG_CHKSUM_EN` defined: each record is followed by an 8th byte equal to the XOR of its 7 bytes. The DRAIN→DONE condition waits for this byte.
- Undefined: 7 bytes per record with no checksum logic.

## Test plan
- Reset and idle:
  - Assert `rst` mid-frame → all outputs return to reset values immediately.
  - With `smp` held high and `arm=0`, no bytes are emitted and `vec_cnt=0`.
- Single record:
  - `NUM_VEC=1`, `byte_rdy=1`. Arm, then `smp` one cycle with `stim=0xC0001234`, `resp=0xABCDEF`.
  - Stream is `C0 00 12 34 AB CD EF`; with the macro defined it is followed by `6F`.
  - `done=1` on the cycle after the last byte's handshake.
- Backpressure:
  - Toggle `byte_rdy` every other cycle.
  - Each byte is held stable while `byte_rdy=0`; byte order is unchanged and no byte is duplicated.
- Overflow:
  - `DEPTH=16`, `byte_rdy=0`, `smp` high for 20 cycles → `vec_cnt=17` (16 in the FIFO plus 1 in the serializer) and `ovfl=1`.
  - Raise `byte_rdy` → exactly 17 records are emitted.
- Full run:
  - `NUM_VEC=1000` with random stim/resp, `smp` every cycle, `byte_rdy=1`.
  - 1000 records are captured (7000 or 8000 bytes) and match a bench-side model with no gaps.
  - `arm` pulses during the run are ignored.
  - A re-arm from DONE clears `vec_cnt` and `ovfl`.
